// File: rtl/wisc_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package wisc_pkg;

  localparam int         WORD_W  = 16;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    REQ    = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus1;
  } fetch_entry_t;

  // Word-address increment; wraps FFFF -> 0000.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory read port: single outstanding request, one-cycle ack pulse.
interface if_prefetch_unit_if;
  import wisc_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/if_fetch_queue.sv
// Prefetch FIFO of {instr, pc+1} entries; flush overrides push and pop, head read is combinational.
module if_fetch_queue
  import wisc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full queue is only legal when the head leaves the same cycle.
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch stage: owns fetch PC, issues credit-limited imem reads, feeds IF/ID from a prefetch queue.
// Optional halt-opcode fetch stop is built when IF_HALT_DETECT_EN is defined.
module if_prefetch_unit
  import wisc_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = OPC_HLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard,
  input  logic                pc_src,
  input  logic [15:0]         pc_branch,
  if_prefetch_unit_if.master  imem,
  output logic                instr_valid,
  output logic [15:0]         instruction,
  output logic [15:0]         pc_out
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  fetch_state_t     state_q, state_d;
  logic             req_q, req_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic [15:0]      last_pc_q, last_pc_d;

  logic             q_push, q_pop, q_empty;
  fetch_entry_t     q_push_data, q_head;
  logic [CNT_W-1:0] q_count, count_after;
  logic             credit, halt_hit;

  if_fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (pc_src),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_comb begin
    q_pop                = !q_empty && !hazard && !pc_src;
    // Acks seen in DROP, or under a redirect, belong to a stale stream.
    q_push               = (state_q == REQ) && imem.imem_ack && !pc_src;
    q_push_data.instr    = imem.imem_rdata;
    q_push_data.pc_plus1 = pc_inc(fetch_pc_q);
    count_after          = pc_src ? '0
                                  : q_count + CNT_W'(q_push) - CNT_W'(q_pop);
    credit               = count_after < CNT_W'(QUEUE_DEPTH);
    halt_hit             = HALT_EN && (imem.imem_rdata[15:12] == HALT_OPCODE);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;

    if (pc_src) begin
      fetch_pc_d = pc_branch;
      // An issued request cannot be withdrawn; wait out its ack in DROP.
      state_d    = (req_q && !imem.imem_ack) ? DROP : REQ;
    end else begin
      case (state_q)
        HOLD: begin
          if (credit) state_d = REQ;
        end
        REQ: begin
          if (imem.imem_ack) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
            if (halt_hit)    state_d = HALTED;
            else if (credit) state_d = REQ;
            else             state_d = HOLD;
          end
        end
        DROP: begin
          if (imem.imem_ack) state_d = REQ;
        end
`ifdef IF_HALT_DETECT_EN
        HALTED: begin
          state_d = HALTED;
        end
`endif
        default: state_d = HOLD;
      endcase
    end

    req_d     = (state_d == REQ) || (state_d == DROP);
    addr_d    = (state_d == DROP) ? addr_q : fetch_pc_d;
    last_pc_d = q_empty ? last_pc_q : q_head.pc_plus1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HOLD;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      last_pc_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= last_pc_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr_valid    = !q_empty;
  assign instruction    = q_empty ? 16'h0000 : q_head.instr;
  assign pc_out         = q_empty ? last_pc_q : q_head.pc_plus1;

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Instruction-fetch stage with a small prefetch queue. It sits between instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues one-outstanding-request reads to instruction memory. Fetched words are buffered and presented to IF/ID with their PC+1, honouring hazard stalls and branch/call/ret redirects from EX.

Parameters:
QUEUE_DEPTH, 4, prefetch queue entries (power of two, 2..8)
RESET_PC, 16'h0000, fetch address after reset
HALT_OPCODE, 4'hF, opcode that stops fetch (optional feature only)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
hazard  input  1  stall from ID; hold the presented instruction
pc_src  input  1  redirect strobe from EX
pc_branch  input  16  redirect target
imem_req  output  1  instruction memory read request
imem_addr  output  16  read address (word address)
imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  input  16  fetched word
instr_valid  output  1  queue head valid
instruction  output  16  queue head word
pc_out  output  16  address of head instruction + 1

Behaviour:
- Reset (rst high at posedge):
  - fetch_pc <= RESET_PC; queue emptied; state <= HOLD.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=16'h0000, pc_out=16'h0000.
- Credit rule: a request may be issued only when count + outstanding < QUEUE_DEPTH. The queue can therefore never overflow on ack.
- States:
  - HOLD: imem_req=0. Go to REQ next cycle when credit is available.
  - REQ: imem_req=1, imem_addr=fetch_pc. Request and address are held stable until imem_ack. On ack:
    - push {imem_rdata, fetch_pc+1}; fetch_pc <= fetch_pc+1 (16-bit wrap, FFFF->0000).
    - Stay in REQ if credit remains after the push, else go to HOLD.
  - DROP: entered when a redirect arrives while a request is unacked. imem_req stays 1 with the old address (requests are never withdrawn). The ack's data is discarded. Next state is REQ at the new fetch_pc.
  - Ack and request are allowed in the same cycle; back-to-back fetches reach 1 word/cycle with a zero-wait memory.
- Output:
  - instr_valid = !empty; instruction/pc_out = head entry (combinational from queue storage).
  - When empty, instruction=16'h0000 and pc_out holds its last value.
  - Pop when instr_valid && !hazard && !pc_src.
  - hazard holds the head indefinitely; prefetch continues until the queue fills.
- Redirect (pc_src=1), highest priority:
  - Same cycle: queue flushed (count<=0), pop ignored, fetch_pc <= pc_branch, and any ack data arriving this cycle is discarded.
  - If imem_req=1 and imem_ack=0 that cycle, go to DROP; otherwise go to REQ (first new request issues the next cycle).
  - Redirect while in DROP: update fetch_pc and stay in DROP.
  - Redirect during hazard: redirect wins.
- Simultaneous push and pop: count unchanged; the pushed entry lands at the tail.
- Push and pop pointers are log2(QUEUE_DEPTH) bits and wrap naturally; count is log2(QUEUE_DEPTH)+1 bits.
- Latency: from rst deassertion to first imem_req is 1 cycle (HOLD->REQ). From ack to instr_valid is 1 cycle.

Optional Feature:
- Macro: IF_HALT_DETECT_EN.
- When defined: an acked word with [15:12]==HALT_OPCODE is pushed normally, then state goes to HALTED. HALTED holds imem_req=0 until a redirect or reset; a redirect behaves as from HOLD.
- When undefined: HALTED does not exist and HALT_OPCODE is unused. Fetch runs continuously.

Decomposition:
- Shared package wisc_pkg:
  - typedef fetch_state_t {HOLD, REQ, DROP, HALTED}
  - typedef fetch_entry_t {instr[15:0], pc_plus1[15:0]}
  - localparam OPC_HLT=4'hF, WORD_W=16
- One sub-module: if_fetch_queue. Synchronous FIFO of fetch_entry_t with push, pop, flush, count, head. Flush has priority over push and pop.

Test Plan:
- Zero-wait memory (ack same cycle as req), rst released, hazard=0 -> addresses 0,1,2,3 on consecutive cycles; instruction at PC 0 appears with pc_out=16'h0001 one cycle after its ack.
- hazard=1 held for 10 cycles -> head stays at the same instruction/pc_out; exactly 4 entries are buffered, then imem_req=0; on release, drains one per cycle.
- Memory with 3-cycle ack latency, pc_src=1 with pc_branch=16'h0040 one cycle after req at address 5 -> imem_addr stays 5 until ack; that data is never presented; next imem_addr=16'h0040; first output pc_out=16'h0041.
- Redirect in the same cycle as an ack and a pop -> queue empty next cycle, acked word dropped, imem_addr=pc_branch.
- fetch_pc=16'hFFFF -> fetched word has pc_out=16'h0000; next imem_addr=16'h0000.
- With IF_HALT_DETECT_EN, memory returns 16'hF000 at address 2 -> entries 0..2 are presented, imem_req stays 0; pc_src with pc_branch=16'h0010 resumes fetch at 16'h0010.
